debug_bridge: RTL and testbench

Byte-command debug controller attached to the processor's halt and debug pins: `wait_for_continue`, `wait_continue_execution`, `debug_get_param`, `debug_reg_addr` and `debug_data_out`. It takes command bytes from a host byte stream (UART RX side) and does one of three things: releases a processor stopped on `wait`, reports halt status, or reads registers r0..r7 and ip through the debug interface. Reply bytes go out on a ready/valid TX stream. The processor is built with `PROCESSOR_DEBUG_INTERFACE` whenever this block is instantiated.

---
 rtl/debug_bridge_if.sv | 40 ++++
 rtl/debug_bridge.sv | 161 ++++++++++++++++
 tb/tb_debug_bridge.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_bridge_if.sv
// ---------------------------------------------------------------------------
// debug_bridge_if
// Signals between the debug bridge, the host byte streams and the processor
// debug pins.
//   rx_data/rx_valid/rx_ready : host command byte stream (ready/valid)
//   tx_data/tx_valid/tx_ready : reply byte stream (ready/valid)
//   wait_for_continue         : processor is stopped on wait
//   wait_continue_execution   : one-cycle release pulse to the processor
//   debug_get_param           : debug read request
//   debug_reg_addr            : 0..7 = r0..r7, 8 = ip
//   debug_data_out            : debug read data from the processor
// slave modport is the bridge side, master modport is the host/processor side.
// ---------------------------------------------------------------------------
interface debug_bridge_if #(
    parameter int WORD_SIZE = 18
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 wait_for_continue;
    logic                 wait_continue_execution;
    logic                 debug_get_param;
    logic [3:0]           debug_reg_addr;
    logic [WORD_SIZE-1:0] debug_data_out;

    modport slave (
        input  rx_data, rx_valid, tx_ready, wait_for_continue, debug_data_out,
        output rx_ready, tx_data, tx_valid, wait_continue_execution,
               debug_get_param, debug_reg_addr
    );

    modport master (
        output rx_data, rx_valid, tx_ready, wait_for_continue, debug_data_out,
        input  rx_ready, tx_data, tx_valid, wait_continue_execution,
               debug_get_param, debug_reg_addr
    );
endinterface

// File: rtl/debug_bridge.sv
// ---------------------------------------------------------------------------
// debug_bridge
// Byte-command debug controller. Decodes host command bytes to release a
// halted processor, report halt status, or read r0..r7/ip through the debug
// interface, and streams reply bytes out.
//   clock : single clock shared with the processor
//   reset : asynchronous, active-high
//   bus   : debug_bridge_if.slave (command/reply streams, debug pins)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a command byte; rx_ready high
// ST_SETTLE  | debug address driven, letting the processor read settle
// ST_CAPTURE | debug_data_out captured on this state's closing edge
// ST_SEND    | reply bytes streamed MSB first from the shift register
// ---------------------------------------------------------------------------
module debug_bridge #(
    parameter int WORD_SIZE = 18
) (
    input  logic          clock,
    input  logic          reset,
    debug_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND
    } state_t;

    state_t      r_state,    w_state_nx;
    logic [23:0] r_shift,    w_shift_nx;
    logic        r_tx_valid, w_tx_valid_nx;
    logic [1:0]  r_byte_cnt, w_byte_cnt_nx;
    logic [3:0]  r_reg_cnt,  w_reg_cnt_nx;
    logic        r_dump,     w_dump_nx;
    logic        r_wce,      w_wce_nx;
    logic        r_dgp,      w_dgp_nx;
    logic [3:0]  r_addr,     w_addr_nx;

    logic [23:0] w_word;
    logic [7:0]  w_reply;
    logic        w_start_read;
    logic        w_start_dump;

    assign w_word = 24'(bus.debug_data_out[WORD_SIZE-1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= 24'h0;
            r_tx_valid <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_reg_cnt  <= 4'd0;
            r_dump     <= 1'b0;
            r_wce      <= 1'b0;
            r_dgp      <= 1'b0;
            r_addr     <= 4'd0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_tx_valid <= w_tx_valid_nx;
            r_byte_cnt <= w_byte_cnt_nx;
            r_reg_cnt  <= w_reg_cnt_nx;
            r_dump     <= w_dump_nx;
            r_wce      <= w_wce_nx;
            r_dgp      <= w_dgp_nx;
            r_addr     <= w_addr_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_tx_valid_nx = r_tx_valid;
        w_byte_cnt_nx = r_byte_cnt;
        w_reg_cnt_nx  = r_reg_cnt;
        w_dump_nx     = r_dump;
        w_wce_nx      = 1'b0;
        w_dgp_nx      = r_dgp;
        w_addr_nx     = r_addr;
        w_reply       = 8'hEE;
        w_start_read  = 1'b0;
        w_start_dump  = 1'b0;

        // Halt status is the wait_for_continue level at the accepting edge.
        if (bus.rx_data == 8'h01) begin
            w_reply = bus.wait_for_continue ? 8'hA1 : 8'hE1;
        end else if (bus.rx_data == 8'h02) begin
            w_reply = {7'b0, bus.wait_for_continue};
        end else if (bus.rx_data[7:4] == 4'h1 && bus.rx_data[3:0] <= 4'd8) begin
            w_reply      = 8'hE1;
            w_start_read = bus.wait_for_continue;
        end else if (bus.rx_data == 8'h20) begin
            w_reply      = 8'hE1;
            w_start_dump = bus.wait_for_continue;
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (w_start_read || w_start_dump) begin
                        w_dgp_nx     = 1'b1;
                        w_addr_nx    = w_start_dump ? 4'd0 : bus.rx_data[3:0];
                        w_reg_cnt_nx = w_start_dump ? 4'd0 : bus.rx_data[3:0];
                        w_dump_nx    = w_start_dump;
                        w_state_nx   = ST_SETTLE;
                    end else begin
                        w_shift_nx    = {w_reply, 16'h0};
                        w_tx_valid_nx = 1'b1;
                        w_byte_cnt_nx = 2'd1;
                        w_wce_nx      = (bus.rx_data == 8'h01) && bus.wait_for_continue;
                        w_state_nx    = ST_SEND;
                    end
                end
            end
            ST_SETTLE: begin
                w_state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_shift_nx    = w_word;
                w_dgp_nx      = 1'b0;
                w_tx_valid_nx = 1'b1;
                w_byte_cnt_nx = 2'd3;
                w_state_nx    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    w_shift_nx    = {r_shift[15:0], 8'h00};
                    w_byte_cnt_nx = r_byte_cnt - 2'd1;
                    if (r_byte_cnt == 2'd1) begin
                        w_tx_valid_nx = 1'b0;
                        // A dump chains straight into the next register read
                        // on the edge that sends the last byte of this one.
                        if (r_dump && r_reg_cnt != 4'd8) begin
                            w_reg_cnt_nx = r_reg_cnt + 4'd1;
                            w_addr_nx    = r_reg_cnt + 4'd1;
                            w_dgp_nx     = 1'b1;
                            w_state_nx   = ST_SETTLE;
                        end else begin
                            w_dump_nx  = 1'b0;
                            w_state_nx = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.rx_ready                = reset | (r_state == ST_IDLE);
    assign bus.tx_data                 = r_shift[23:16];
    assign bus.tx_valid                = r_tx_valid;
    assign bus.wait_continue_execution = r_wce;
    assign bus.debug_get_param         = r_dgp;
    assign bus.debug_reg_addr          = r_addr;

endmodule

// File: tb/tb_debug_bridge.sv
module tb_debug_bridge;
    localparam int WS = 18;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    debug_bridge_if #(.WORD_SIZE(WS)) bif ();

    debug_bridge #(.WORD_SIZE(WS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // processor model: register file read combinationally by debug address
    logic [WS-1:0] regs [0:15];
    assign bif.debug_data_out = regs[bif.debug_reg_addr];

    // tx_ready: 0 = held high, 1 = random, 2 = held low
    int rdy_mode = 0;
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       bif.tx_ready = 1'b1;
            1:       bif.tx_ready = 1'($urandom_range(0, 1));
            default: bif.tx_ready = 1'b0;
        endcase
    end

    // monitor: only appends/increments; main process takes deltas
    logic [7:0] got[$];
    int         got_addr[$];
    int         pulses = 0, dbl = 0, overlap = 0, txv_rise_cyc = 0;
    logic       prev_wce = 1'b0, prev_txv = 1'b0;
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            if (bif.tx_valid && bif.tx_ready) got.push_back(bif.tx_data);
            if (bif.tx_valid && !prev_txv) txv_rise_cyc = cyc;
            if (bif.wait_continue_execution) begin
                pulses++;
                if (prev_wce) dbl++;
            end
            if (bif.debug_get_param) got_addr.push_back(int'(bif.debug_reg_addr));
            if (bif.tx_valid && bif.rx_ready) overlap++;
            prev_wce = bif.wait_continue_execution;
            prev_txv = bif.tx_valid;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cmd_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: reply bytes, release pulses and debug addresses
    logic [7:0] exp_bytes[$];
    int         exp_addr[$];
    int         exp_pulses;

    task automatic model(input logic [7:0] c, input bit h);
        int first, last, w;
        exp_bytes.delete();
        exp_addr.delete();
        exp_pulses = 0;
        if (c == 8'h01) begin
            exp_bytes.push_back(h ? 8'hA1 : 8'hE1);
            exp_pulses = h ? 1 : 0;
        end else if (c == 8'h02) begin
            exp_bytes.push_back(h ? 8'h01 : 8'h00);
        end else if ((c >= 8'h10 && c <= 8'h18) || c == 8'h20) begin
            if (!h) begin
                exp_bytes.push_back(8'hE1);
            end else begin
                first = (c == 8'h20) ? 0 : int'(c) - 16;
                last  = (c == 8'h20) ? 8 : int'(c) - 16;
                for (int k = first; k <= last; k++) begin
                    w = int'(regs[k]);
                    exp_bytes.push_back(8'((w / 65536) % 256));
                    exp_bytes.push_back(8'((w / 256) % 256));
                    exp_bytes.push_back(8'(w % 256));
                    exp_addr.push_back(k);
                    exp_addr.push_back(k);
                end
            end
        end else begin
            exp_bytes.push_back(8'hEE);
        end
    endtask

    task automatic present(input logic [7:0] c, input bit h, input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            ok = bif.rx_ready;
        end
        check({tag, "_rdy_wait"}, 32'(ok), 32'd1);
        bif.wait_for_continue = h;
        bif.rx_data  = c;
        bif.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_cyc      = cyc;
        bif.rx_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] c, input bit h, input int exp_rise,
                           input int exp_done, input string tag);
        int gb, pb, ab, ob, db, done_lat, n;
        bit done = 0;
        model(c, h);
        gb = got.size(); pb = pulses; ab = got_addr.size(); ob = overlap; db = dbl;
        present(c, h, tag);
        done_lat = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (bif.rx_ready) begin
                done = 1;
                done_lat = cyc - cmd_cyc;
            end
        end
        check({tag, "_timeout"}, 32'(done), 32'd1);
        check({tag, "_nbytes"}, 32'(got.size() - gb), 32'(exp_bytes.size()));
        n = (got.size() - gb < exp_bytes.size()) ? got.size() - gb : exp_bytes.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[gb + i]), 32'(exp_bytes[i]));
        check({tag, "_pulses"}, 32'(pulses - pb), 32'(exp_pulses));
        check({tag, "_dbl_pulse"}, 32'(dbl - db), 32'd0);
        check({tag, "_dgp_cycles"}, 32'(got_addr.size() - ab), 32'(exp_addr.size()));
        n = (got_addr.size() - ab < exp_addr.size()) ? got_addr.size() - ab : exp_addr.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[ab + i]), 32'(exp_addr[i]));
        check({tag, "_rx_ready_busy"}, 32'(overlap - ob), 32'd0);
        if (exp_rise >= 0) check({tag, "_tx_latency"}, 32'(txv_rise_cyc - cmd_cyc), 32'(exp_rise));
        if (exp_done >= 0) check({tag, "_done_latency"}, 32'(done_lat), 32'(exp_done));
    endtask

    initial begin
        logic [7:0] cmds [0:14];
        logic [7:0] c;
        bit h;
        int gb, nd;

        bif.rx_data = 8'h00;
        bif.rx_valid = 1'b0;
        bif.wait_for_continue = 1'b0;
        for (int k = 0; k < 16; k++) regs[k] = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_tx_valid", 32'(bif.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bif.tx_data), 32'd0);
        check("rst_wce", 32'(bif.wait_continue_execution), 32'd0);
        check("rst_dgp", 32'(bif.debug_get_param), 32'd0);
        check("rst_addr", 32'(bif.debug_reg_addr), 32'd0);
        check("rst_rx_ready", 32'(bif.rx_ready), 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // directed
        run_cmd(8'h01, 1'b1, 0, 1, "cont_halted");
        run_cmd(8'h01, 1'b0, 0, 1, "cont_running");
        regs[3] = 18'h2A5C3;
        run_cmd(8'h13, 1'b1, 2, 5, "read_r3");
        run_cmd(8'h18, 1'b0, 0, 1, "read_ip_running");
        run_cmd(8'h7F, 1'b1, 0, 1, "unknown_7f");
        run_cmd(8'h19, 1'b1, 0, 1, "unknown_19");
        run_cmd(8'h02, 1'b1, 0, 1, "status_halted");
        run_cmd(8'h02, 1'b0, 0, 1, "status_running");

        for (int k = 0; k < 8; k++) regs[k] = 18'h10000 + 18'(k);
        regs[8] = 18'h00123;
        run_cmd(8'h20, 1'b1, -1, 45, "dump_fast");
        rdy_mode = 1;
        gb = got.size();
        run_cmd(8'h20, 1'b1, -1, -1, "dump_rand");
        nd = got.size();
        if (nd - gb >= 3) begin
            check("dump_last0", 32'(got[nd - 3]), 32'h00);
            check("dump_last1", 32'(got[nd - 2]), 32'h01);
            check("dump_last2", 32'(got[nd - 1]), 32'h23);
        end else begin
            check("dump_last_count", 32'(nd - gb), 32'd27);
        end
        rdy_mode = 0;
        run_cmd(8'h20, 1'b0, 0, 1, "dump_running");

        // reset in the middle of a stalled READ_REG reply
        rdy_mode = 2;
        regs[5] = 18'h3BEEF;
        present(8'h15, 1'b1, "rst_mid");
        repeat (4) @(negedge clock);
        check("rst_mid_stalled", 32'(bif.tx_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx_valid", 32'(bif.tx_valid), 32'd0);
        check("rst_mid_tx_data", 32'(bif.tx_data), 32'd0);
        check("rst_mid_addr", 32'(bif.debug_reg_addr), 32'd0);
        check("rst_mid_dgp", 32'(bif.debug_get_param), 32'd0);
        check("rst_mid_rx_ready", 32'(bif.rx_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        rdy_mode = 0;
        gb = got.size();
        repeat (10) @(negedge clock);
        check("rst_mid_no_stale", 32'(got.size() - gb), 32'd0);
        check("rst_mid_idle", 32'(bif.rx_ready), 32'd1);

        // randomized commands against the reference model
        cmds = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h14, 8'h16, 8'h17,
                 8'h18, 8'h1C, 8'h20, 8'h00, 8'hFF, 8'h21, 8'h03};
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 9; k++) regs[k] = 18'($urandom);
            c = ($urandom_range(0, 4) == 0) ? 8'($urandom) : cmds[$urandom_range(0, 14)];
            h = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 1);
            run_cmd(c, h, -1, -1, $sformatf("rand%0d_cmd%02h", t, c));
        end
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
